// File: rtl/jtframe_romarb_pkg.sv
// ============================================================================
// Module : jtframe_romarb_pkg
// Brief  : Shared arbiter state encoding and slot data-width legality helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package jtframe_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Bit n set means a slot data width of n bytes is supported.
    localparam logic [4:0] DW_LEGAL_MASK = 5'b10110;

    function automatic bit dw_legal(input int dw);
        if (dw <= 0 || dw > 32 || (dw % 8) != 0) return 1'b0;
        return DW_LEGAL_MASK[3'(dw / 8)];
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_romrq.sv
// ============================================================================
// Module : jtframe_romrq
// Brief  : One read slot: address cache (one or two entries), request strobe
//          and data-valid generation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jtframe_romrq
    import jtframe_romarb_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter bit LATCH   = 1'b0,
    parameter bit DOUBLE  = 1'b0,
    parameter bit OKLATCH = 1'b1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic [15:0]   din,
    input  logic          din_ok,
    input  logic          we,
    output logic          req,
    output logic [AW-1:0] addr_req,
    output logic [DW-1:0] dout,
    output logic          data_ok
);

    localparam int NE = DOUBLE ? 2 : 1;

    logic [AW-1:0] tag_q   [NE];
    logic [DW-1:0] data_q  [NE];
    logic [NE-1:0] valid_q;
    logic          victim_q;
    logic [AW-1:0] cur_addr;
    logic          hit;

    generate
        if (LATCH) begin : g_latch
            logic          cs_q;
            logic [AW-1:0] addr_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cs_q   <= 1'b0;
                    addr_q <= '0;
                end else begin
                    cs_q <= cs;
                    if (cs && !cs_q) addr_q <= addr;
                end
            end
            // The address is sampled on the rising edge of cs and held after.
            assign cur_addr = (cs && !cs_q) ? addr : addr_q;
        end else begin : g_nolatch
            assign cur_addr = addr;
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        dout = '0;
        for (int e = 0; e < NE; e++) begin
            if (valid_q[e] && tag_q[e] == cur_addr) begin
                hit  = 1'b1;
                dout = data_q[e];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            victim_q <= 1'b0;
            for (int e = 0; e < NE; e++) begin
                tag_q[e]  <= '0;
                data_q[e] <= '0;
            end
        end else if (clr) begin
            valid_q <= '0;
        end else if (we && din_ok) begin
            for (int e = 0; e < NE; e++) begin
                if (e == int'(victim_q)) begin
                    tag_q[e]   <= cur_addr;
                    data_q[e]  <= DW'(din);
                    valid_q[e] <= 1'b1;
                end
            end
            if (DOUBLE) victim_q <= ~victim_q;
        end
    end

    generate
        if (OKLATCH) begin : g_oklatch
            assign data_ok = cs && hit;
        end else begin : g_okpulse
            logic okp_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) okp_q <= 1'b0;
                else     okp_q <= we && din_ok;
            end
            assign data_ok = okp_q;
        end
    endgenerate

    assign req      = cs && !hit;
    assign addr_req = cur_addr;

endmodule

`default_nettype wire

// File: rtl/jtframe_rom_nslots.sv
// ============================================================================
// Module : jtframe_rom_nslots
// Brief  : N-slot SDRAM read arbiter. Define JTFRAME_ROMARB_RR_EN for
//          round-robin arbitration; default is fixed priority (slot 0 first).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jtframe_rom_nslots
    import jtframe_romarb_pkg::*;
#(
    parameter int                        SLOTS   = 4,
    parameter int                        SDRAMW  = 22,
    parameter int                        AW      = 8,
    parameter int                        DW      = 8,
    parameter logic [SLOTS*SDRAMW-1:0]   OFFSETS = '0,
    parameter logic [SLOTS-1:0]          LATCH   = '0,
    parameter logic [SLOTS-1:0]          DOUBLE  = '0,
    parameter logic [SLOTS-1:0]          OKLATCH = {SLOTS{1'b1}}
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SLOTS*AW-1:0]     slot_addr,
    input  logic [SLOTS-1:0]        slot_cs,
    output logic [SLOTS*DW-1:0]     slot_dout,
    output logic [SLOTS-1:0]        slot_ok,
    output logic                    sdram_req,
    output logic [SDRAMW-1:0]       sdram_addr,
    input  logic                    sdram_ack,
    input  logic                    data_dst,
    input  logic                    data_rdy,
    input  logic [15:0]             data_read,
    output logic [SLOTS-1:0]        grant,
    output logic                    err
);

    localparam int IW = $clog2(SLOTS);

    arb_state_e        state_q, state_d;
    logic [SLOTS-1:0]  grant_q, grant_d;
    logic              req_q, req_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [SLOTS-1:0]  slot_req;
    logic [SLOTS-1:0]  eligible;
    logic [AW-1:0]     rq_addr   [SLOTS];
    logic [SDRAMW-1:0] full_addr [SLOTS];
    logic [IW-1:0]     pick;
    logic              found;
    logic              load;
    logic              done;
    logic              rd_ok;
    logic              w_unused;

    generate
        if (!dw_legal(DW)) begin : g_bad_dw
            $error("jtframe_rom_nslots: DW must be 8, 16 or 32");
        end
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            jtframe_romrq #(
                .AW      (AW),
                .DW      (DW),
                .LATCH   (LATCH[i]),
                .DOUBLE  (DOUBLE[i]),
                .OKLATCH (OKLATCH[i])
            ) u_romrq (
                .clk      (clk),
                .rst      (rst),
                .clr      (1'b0),
                .addr     (slot_addr[i*AW +: AW]),
                .cs       (slot_cs[i]),
                .din      (data_read),
                .din_ok   (rd_ok),
                .we       (grant_q[i]),
                .req      (slot_req[i]),
                .addr_req (rq_addr[i]),
                .dout     (slot_dout[i*DW +: DW]),
                .data_ok  (slot_ok[i])
            );
            assign full_addr[i] = SDRAMW'(rq_addr[i]) + OFFSETS[i*SDRAMW +: SDRAMW];
        end
    endgenerate

    // The slot currently owning the bus never competes in its own re-arbitration.
    assign eligible = slot_req & ~grant_q;
    assign rd_ok    = data_rdy && ((state_q == ST_WAIT) || (state_q == ST_REQ && sdram_ack));
    assign w_unused = data_dst;

`ifdef JTFRAME_ROMARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (eligible[IW'((int'(ptr_q) + k) % SLOTS)]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr_q) + k) % SLOTS);
            end
        end
        ptr_d = load ? IW'((int'(pick) + 1) % SLOTS) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found = 1'b1;
                pick  = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_d   = req_q;
        addr_d  = addr_q;
        err_d   = err_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_rdy || sdram_ack) err_d = 1'b1;
                if (found) load = 1'b1;
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    if (data_rdy) begin
                        done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        req_d   = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_ack) err_d = 1'b1;
                if (data_rdy)  done  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            if (found) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                req_d   = 1'b0;
            end
        end
        if (load) begin
            state_d = ST_REQ;
            grant_d = {{(SLOTS-1){1'b0}}, 1'b1} << pick;
            addr_d  = full_addr[pick];
            req_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign grant      = grant_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_rom_nslots.sv
// ============================================================================
// Module : tb_jtframe_rom_nslots
// Brief  : Self-checking bench for jtframe_rom_nslots (honours
//          JTFRAME_ROMARB_RR_EN in its arbitration model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_jtframe_rom_nslots;

    localparam int SLOTS  = 4;
    localparam int AW     = 8;
    localparam int SDRAMW = 22;
    localparam int DW     = 16;
    localparam logic [SLOTS*SDRAMW-1:0] OFFS = {22'h3FFF80, 22'h001000, 22'h000200, 22'h000000};

    int off_tab [SLOTS] = '{'h0, 'h200, 'h1000, 'h3FFF80};

    logic                  clk = 1'b0;
    logic                  rst;
    logic [SLOTS*AW-1:0]   slot_addr;
    logic [SLOTS-1:0]      slot_cs;
    logic [SLOTS*DW-1:0]   slot_dout;
    logic [SLOTS-1:0]      slot_ok;
    logic                  sdram_req;
    logic [SDRAMW-1:0]     sdram_addr;
    logic                  sdram_ack;
    logic                  data_dst;
    logic                  data_rdy;
    logic [15:0]           data_read;
    logic [SLOTS-1:0]      grant;
    logic                  err;

    jtframe_rom_nslots #(
        .SLOTS(SLOTS), .SDRAMW(SDRAMW), .AW(AW), .DW(DW), .OFFSETS(OFFS)
    ) dut (
        .clk(clk), .rst(rst), .slot_addr(slot_addr), .slot_cs(slot_cs),
        .slot_dout(slot_dout), .slot_ok(slot_ok), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_dst(data_dst),
        .data_rdy(data_rdy), .data_read(data_read), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what each slot is asking for and what it has cached.
    int cur_addr [SLOTS];
    bit cvalid   [SLOTS];
    int caddr    [SLOTS];
    int rr_ptr;

    typedef struct {
        int          slot;
        int          addr;
        logic [15:0] data;
        logic [21:0] exp;
        bit          same;
    } vec_t;

    vec_t tab [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [SLOTS-1:0] pend);
`ifdef JTFRAME_ROMARB_RR_EN
        for (int k = 0; k < SLOTS; k++)
            if (pend[(rr_ptr + k) % SLOTS]) return (rr_ptr + k) % SLOTS;
`else
        for (int k = 0; k < SLOTS; k++)
            if (pend[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [21:0] model_addr(input int s);
        return 22'((off_tab[s] + cur_addr[s]) & 'h3FFFFF);
    endfunction

    function automatic int new_addr(input int s);
        int a;
        do a = int'($urandom_range(0, 255)); while (cvalid[s] && a == caddr[s]);
        return a;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SLOTS; s++) cvalid[s] = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic set_slot(input int s, input int a);
        slot_addr[s*AW +: AW] = AW'(a);
        cur_addr[s] = a;
        slot_cs[s]  = 1'b1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        tick();
    endtask

    // One full transaction for slot s, from waiting on sdram_req to the data edge.
    task automatic do_txn(input int s, input logic [21:0] ea, input logic [15:0] d,
                          input int ack_dly, input int rdy_dly, input bit same);
        int n = 0;
        while (!sdram_req && n < 8) begin tick(); n++; end
        check("req_up", 32'(sdram_req), 32'd1);
        check("grant", 32'(grant), 32'(1 << s));
        check("sdram_addr", 32'(sdram_addr), 32'(ea));
        rr_ptr = (s + 1) % SLOTS;
        repeat (ack_dly) tick();
        sdram_ack = 1'b1;
        if (same) begin
            data_rdy = 1'b1; data_read = d;
            tick();
            sdram_ack = 1'b0; data_rdy = 1'b0;
        end else begin
            tick();
            sdram_ack = 1'b0;
            check("req_drop", 32'(sdram_req), 32'd0);
            check("grant_hold", 32'(grant), 32'(1 << s));
            repeat (rdy_dly) tick();
            data_rdy = 1'b1; data_read = d;
            tick();
            data_rdy = 1'b0;
        end
        check("slot_ok", 32'(slot_ok[s]), 32'd1);
        check("slot_dout", 32'(slot_dout[s*DW +: DW]), 32'(d));
        cvalid[s] = 1'b1;
        caddr[s]  = cur_addr[s];
    endtask

    // Raise cs on every slot of mask with fresh addresses; serve all in model order.
    task automatic run_set(input logic [SLOTS-1:0] mask, input int same_mode);
        logic [SLOTS-1:0] pend = mask;
        int s;
        for (int k = 0; k < SLOTS; k++) if (mask[k]) set_slot(k, new_addr(k));
        while (pend != '0) begin
            s = model_pick(pend);
            do_txn(s, model_addr(s), 16'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)),
                   same_mode < 0 ? bit'($urandom_range(0, 1)) : bit'(same_mode));
            pend[s] = 1'b0;
            if (pend != '0) check("req_same_edge", 32'(sdram_req), 32'd1);
            else            check("idle_grant", 32'(grant), 32'd0);
        end
        slot_cs = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ord [4] = '{0, 1, 0, 1};
        logic [SLOTS-1:0] ok_before;
        logic [15:0] d0;

        rst = 1'b1; slot_addr = '0; slot_cs = '0; sdram_ack = 1'b0;
        data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
        model_clear();
        tick(); tick();
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ok", 32'(slot_ok), 32'd0);
        check("rst_dout", slot_dout[31:0], 32'd0);
        rst = 1'b0;
        tick();

        tab[0] = '{2, 'h10, 16'hBEEF, 22'h001010, 1'b0};
        tab[1] = '{0, 'hFF, 16'h1234, 22'h0000FF, 1'b0};
        tab[2] = '{1, 'h00, 16'h5A5A, 22'h000200, 1'b1};
        tab[3] = '{3, 'hA0, 16'hCAFE, 22'h000020, 1'b0};
        tab[4] = '{3, 'h7F, 16'h0F0F, 22'h3FFFFF, 1'b1};
        tab[5] = '{2, 'hFF, 16'hFFFF, 22'h0010FF, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_slot(tab[i].slot, tab[i].addr);
            do_txn(tab[i].slot, tab[i].exp, tab[i].data, 1, 1, tab[i].same);
            check("vec_idle", 32'(grant), 32'd0);
            slot_cs = '0;
            tick();
            check("vec_ok_drop", 32'(slot_ok), 32'd0);
        end

        // Slots 0, 1 and 3 together.
        reset_dut();
        run_set(4'b1011, -1);

        // Two permanently requesting slots alternate.
        reset_dut();
        set_slot(0, new_addr(0));
        set_slot(1, new_addr(1));
        for (int k = 0; k < 4; k++) begin
            do_txn(ord[k], model_addr(ord[k]), 16'($urandom), 0, 1, 1'b0);
            if (k < 3) check("rr_same_edge", 32'(sdram_req), 32'd1);
            if (k < 2) set_slot(ord[k], new_addr(ord[k]));
        end
        check("rr_end_grant", 32'(grant), 32'd0);
        slot_cs = '0;
        tick();

        // ack and data_rdy together, next grant with no bubble.
        reset_dut();
        run_set(4'b0110, 1);

        // Spurious data_rdy in IDLE, with a cached slot still selected.
        reset_dut();
        set_slot(0, new_addr(0));
        d0 = 16'h3C3C;
        do_txn(0, model_addr(0), d0, 0, 0, 1'b0);
        tick();
        ok_before = slot_ok;
        data_read = ~d0; data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        check("spur_err", 32'(err), 32'd1);
        check("spur_ok", 32'(slot_ok), 32'(ok_before));
        check("spur_dout", 32'(slot_dout[15:0]), 32'(d0));
        check("spur_grant", 32'(grant), 32'd0);
        check("spur_req", 32'(sdram_req), 32'd0);
        repeat (3) tick();
        check("spur_err_held", 32'(err), 32'd1);
        reset_dut();
        check("spur_err_clr", 32'(err), 32'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("spur_ack_err", 32'(err), 32'd1);
        reset_dut();
        check("spur_ack_clr", 32'(err), 32'd0);

        // Reset while waiting for data.
        set_slot(0, new_addr(0));
        tick();
        check("rw_req", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("rw_wait", 32'(sdram_req), 32'd0);
        check("rw_wait_grant", 32'(grant), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rw_async_grant", 32'(grant), 32'd0);
        check("rw_async_req", 32'(sdram_req), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        do_txn(0, model_addr(0), 16'hA5A5, 0, 0, 1'b0);
        check("rw_restart_err", 32'(err), 32'd0);
        slot_cs = '0;
        tick();

        // Random request sets.
        reset_dut();
        for (int r = 0; r < 30; r++) begin
            run_set(SLOTS'($urandom_range(1, (1 << SLOTS) - 1)), -1);
            check("rand_err", 32'(err), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
